// File: rtl/xc_malu_multiply_if.sv
// Request/response bundle for the iterative multiplier.
// The requester (master) drives the operands, opcode, valid and flush;
// the multiplier (slave) returns the product word, the ready pulse and busy.
interface xc_malu_multiply_if;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        valid;
   logic [1:0]  op;
   logic        flush;
   logic [31:0] result;
   logic        ready;
   logic        busy;

   modport master (
      output rs1,
      output rs2,
      output valid,
      output op,
      output flush,
      input  result,
      input  ready,
      input  busy
   );

   modport slave (
      input  rs1,
      input  rs2,
      input  valid,
      input  op,
      input  flush,
      output result,
      output ready,
      output busy
   );
endinterface

// File: rtl/xc_malu_multiply.sv
// Iterative shift-and-add multiplier for mul / mulh / mulhsu / mulhu.
//
// Operands are converted to unsigned magnitudes when a request is accepted,
// and one multiplier bit is consumed per RUN cycle. The sign of the product
// is restored when the last RUN cycle hands over to FIN.
//
// Optional build macro: XC_MALU_MUL_EARLY_EXIT_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero, so RUN lasts 1 to 32 cycles. Results are identical either way,
//   since the skipped cycles could only have added zero.
//
// result and ready are loaded on the edge that enters FIN, so both are
// visible for the whole FIN cycle; ready drops again when FIN returns to IDLE.
module xc_malu_multiply (
   input  logic               clock,
   input  logic               resetn,
   xc_malu_multiply_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   state_t      state;
   logic [5:0]  count;
   logic [63:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [1:0]  op_q;
   logic        neg;
   logic [31:0] result_q;
   logic        ready_q;

   logic        rs1_signed;
   logic        rs2_signed;
   logic [31:0] rs1_mag;
   logic [31:0] rs2_mag;
   logic        neg_in;
   logic [63:0] partial;
   logic [63:0] acc_sum;
   logic [63:0] product;
   logic [31:0] mplier_shift;
   logic [31:0] result_next;
   logic        last_step;

   // Decode operand signedness from the incoming opcode and form the
   // magnitudes and product sign that get latched on acceptance.
   // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
   always_comb begin
      rs1_signed = 1'b0;
      rs2_signed = 1'b0;
      if (bus.op == OP_MULH) begin
         rs1_signed = 1'b1;
         rs2_signed = 1'b1;
      end else if (bus.op == OP_MULHSU) begin
         rs1_signed = 1'b1;
      end
      rs1_mag = (rs1_signed && bus.rs1[31]) ? (~bus.rs1 + 32'd1) : bus.rs1;
      rs2_mag = (rs2_signed && bus.rs2[31]) ? (~bus.rs2 + 32'd1) : bus.rs2;
      neg_in  = (rs1_signed & bus.rs1[31]) ^ (rs2_signed & bus.rs2[31]);
   end

   // One shift-and-add step, plus the signed, word-selected view of the
   // accumulator as it will stand after this step.
   always_comb begin
      partial      = mplier[0] ? ({32'd0, mcand} << count) : 64'd0;
      acc_sum      = acc + partial;
      product      = neg ? (~acc_sum + 64'd1) : acc_sum;
      result_next  = (op_q == OP_MUL) ? product[31:0] : product[63:32];
      mplier_shift = mplier >> 1;
`ifdef XC_MALU_MUL_EARLY_EXIT_EN
      last_step    = (count == 6'd31) || (mplier_shift == 32'd0);
`else
      last_step    = (count == 6'd31);
`endif
   end

   // Control FSM and datapath registers; reset beats flush, flush beats valid.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state    <= IDLE;
         ready_q  <= 1'b0;
         result_q <= 32'd0;
         count    <= 6'd0;
         acc      <= 64'd0;
         mcand    <= 32'd0;
         mplier   <= 32'd0;
         op_q     <= OP_MUL;
         neg      <= 1'b0;
      end else if (bus.flush) begin
         state   <= IDLE;
         ready_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= 1'b0;
               if (bus.valid) begin
                  mcand  <= rs1_mag;
                  mplier <= rs2_mag;
                  op_q   <= bus.op;
                  neg    <= neg_in;
                  acc    <= 64'd0;
                  count  <= 6'd0;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_sum;
               mplier <= mplier_shift;
               count  <= count + 6'd1;
               if (last_step) begin
                  result_q <= result_next;
                  ready_q  <= 1'b1;
                  state    <= FIN;
               end
            end
            FIN: begin
               ready_q <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.ready  = ready_q;
   assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_xc_malu_multiply.sv
// Self-checking bench for xc_malu_multiply.
// Expected products come from a 66-bit signed reference multiply and are
// queued when a request is driven, then popped when ready pulses.
module tb_xc_malu_multiply;

   logic clock;
   logic resetn;

   xc_malu_multiply_if bus ();

   xc_malu_multiply dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0] res;
      int          lat;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          assertCount = 0;
   int          failCount   = 0;
   int          readyPulses = 0;
   logic [31:0] lastResult  = 32'd0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count every ready cycle so aborted operations can be shown to stay silent.
   always @(negedge clock) begin
      if (bus.ready === 1'b1) readyPulses++;
   end

   // Overall time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] x;
      logic signed [65:0] y;
      logic signed [65:0] p;
      x = (o == 2'b01 || o == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
      y = (o == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
      p = x * y;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Cycle index (1 = cycle starting at the accepting edge) in which ready is high.
   function automatic int expLatency(input logic [1:0] o, input logic [31:0] b);
`ifdef XC_MALU_MUL_EARLY_EXIT_EN
      logic [31:0] m;
      int          n;
      m = (o == 2'b01 && b[31]) ? (~b + 32'd1) : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return n + 1;
`else
      return (o == 2'b11 && b == 32'd0) ? 33 : 33;
`endif
   endfunction

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a request and wait for its accepting edge, then scramble the
   // operand inputs to show they are no longer looked at.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input string tag, input bit push);
      exp_t e;
      if (push) begin
         e.res = model(o, a, b);
         e.lat = expLatency(o, b);
         e.tag = tag;
         sb.push_back(e);
      end
      bus.op    = o;
      bus.rs1   = a;
      bus.rs2   = b;
      bus.valid = 1'b1;
      @(posedge clock);
      #1;
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      bus.op  = 2'($urandom_range(0, 3));
   endtask

   // Wait (bounded) for ready, compare against the scoreboard head, then
   // step past FIN and confirm the pulse was a single cycle.
   task automatic checkOutput(input bit keepValid);
      exp_t e;
      bit   seen;
      int   k;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         @(negedge clock);
         k++;
         if (bus.ready === 1'b1) seen = 1'b1;
      end
      e = sb.pop_front();
      checkValue({e.tag, "_ready_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         checkValue({e.tag, "_result"}, 64'(bus.result), 64'(e.res));
         checkValue({e.tag, "_latency"}, 64'(k), 64'(e.lat));
         lastResult = e.res;
      end
      if (!keepValid) bus.valid = 1'b0;
      @(posedge clock);
      #1;
      checkValue({e.tag, "_ready_one_cycle"}, 64'(bus.ready), 64'd0);
      checkValue({e.tag, "_idle_after_fin"}, 64'(bus.busy), 64'd0);
   endtask

   int pulses0;

   initial begin
      resetn    = 1'b0;
      bus.valid = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 2'b00;
      bus.rs1   = 32'd0;
      bus.rs2   = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      checkValue("reset_ready", 64'(bus.ready), 64'd0);
      checkValue("reset_busy", 64'(bus.busy), 64'd0);
      checkValue("reset_result", 64'(bus.result), 64'd0);
      resetn = 1'b1;

      // Directed corner products
      applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, "mulh_min_min", 1'b1);
      checkOutput(1'b0);
      checkValue("mulh_min_min_const", 64'(lastResult), 64'h4000_0000);
      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones", 1'b1);
      checkOutput(1'b0);
      checkValue("mul_ones_const", 64'(lastResult), 64'h0000_0001);
      applyStimulus(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones", 1'b1);
      checkOutput(1'b0);
      checkValue("mulhu_ones_const", 64'(lastResult), 64'hFFFF_FFFE);
      applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones", 1'b1);
      checkOutput(1'b0);
      checkValue("mulhsu_ones_const", 64'(lastResult), 64'hFFFF_FFFF);
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones", 1'b1);
      checkOutput(1'b0);
      checkValue("mulh_ones_const", 64'(lastResult), 64'h0000_0000);
      applyStimulus(2'b00, 32'h1234_5678, 32'h0000_0001, "mul_by_one", 1'b1);
      checkOutput(1'b0);
      applyStimulus(2'b10, 32'h8000_0000, 32'h0000_0000, "mulhsu_by_zero", 1'b1);
      checkOutput(1'b0);

      // valid held through FIN: ignored there, accepted in the following IDLE
      applyStimulus(2'b00, 32'd7, 32'd9, "b2b_first", 1'b1);
      checkOutput(1'b1);
      applyStimulus(2'b11, 32'hDEAD_BEEF, 32'hCAFE_BABE, "b2b_second", 1'b1);
      checkOutput(1'b0);

      // A few random operations of every opcode
      for (int i = 0; i < 6; i++) begin
         applyStimulus(2'(i % 4), $urandom, $urandom, $sformatf("rand%0d", i), 1'b1);
         checkOutput(1'b0);
      end

      // Flush during the 10th RUN cycle
      pulses0 = readyPulses;
      applyStimulus(2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF, "flush_op", 1'b0);
      repeat (9) @(posedge clock);
      #1;
      checkValue("flush_busy_before", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      bus.valid = 1'b0;
      @(posedge clock);
      #1;
      bus.flush = 1'b0;
      checkValue("flush_busy_after", 64'(bus.busy), 64'd0);
      repeat (40) @(negedge clock);
      checkValue("flush_no_ready", 64'(readyPulses), 64'(pulses0));
      checkValue("flush_result_hold", 64'(bus.result), 64'(lastResult));
      #1;
      applyStimulus(2'b00, 32'd3, 32'd5, "after_flush", 1'b1);
      checkOutput(1'b0);
      checkValue("after_flush_const", 64'(lastResult), 64'h0000_000F);

      // Reset during the 20th RUN cycle with valid still asserted
      pulses0 = readyPulses;
      applyStimulus(2'b00, 32'h0000_ABCD, 32'h00FF_00FF, "reset_op", 1'b0);
      repeat (19) @(posedge clock);
      #1;
      checkValue("reset_mid_busy_before", 64'(bus.busy), 64'd1);
      resetn  = 1'b0;
      bus.op  = 2'b00;
      bus.rs1 = 32'h0000_ABCD;
      bus.rs2 = 32'h00FF_00FF;
      @(posedge clock);
      #1;
      checkValue("reset_mid_result", 64'(bus.result), 64'd0);
      checkValue("reset_mid_busy", 64'(bus.busy), 64'd0);
      checkValue("reset_mid_ready", 64'(bus.ready), 64'd0);
      checkValue("reset_mid_no_ready", 64'(readyPulses), 64'(pulses0));
      resetn = 1'b1;
      applyStimulus(2'b00, 32'h0000_ABCD, 32'h00FF_00FF, "reset_restart", 1'b1);
      checkValue("reset_restart_busy", 64'(bus.busy), 64'd1);
      checkOutput(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
